// File: rtl/rgb_slice_writer.sv
// rgb_slice_writer: packs the SBC parallel RGB stream into 16-bit voxels and writes whole slices into a RAM ring.
// Optional feature macro: RGB_SLICE_WRITER_ROUND_EN (rounded channel packing instead of truncation).
`default_nettype none

module rgb_slice_writer #(
    parameter int unsigned                RAM_ADDR_WIDTH = 32,
    parameter int unsigned                RAM_DATA_WIDTH = 16,
    parameter logic [RAM_ADDR_WIDTH-1:0]  RAM_BASE       = '0,
    parameter int unsigned                IMAGE_SIZE     = 1920,
    parameter int unsigned                SLICES_IN_RAM  = 18,
    parameter int unsigned                PRELOAD_SLICES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [23:0]               rgb,
    input  logic                      rgb_valid,
    input  logic                      vsync,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data,
    output logic                      ram_we,
    output logic                      stream_ready,
    output logic [4:0]                slice_count
);

    // state      | meaning
    // WAIT_FRAME | idle between frames, pixels ignored until a vsync rising edge
    // FILL       | accepting pixels of the current slice, one RAM write per pixel
    // DONE       | full slice written; advance the ring and count it (one cycle)

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        FILL       = 2'd1,
        DONE       = 2'd2
    } state_t;

    localparam int unsigned PIX_W = $clog2(IMAGE_SIZE + 1);
    localparam int unsigned IDX_W = (SLICES_IN_RAM > 1) ? $clog2(SLICES_IN_RAM) : 1;

    localparam logic [PIX_W-1:0]          LAST_PIX    = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [IDX_W-1:0]          LAST_IDX    = IDX_W'(SLICES_IN_RAM - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] SLICE_STEP  = RAM_ADDR_WIDTH'(IMAGE_SIZE);
    localparam logic [4:0]                PRELOAD_CNT = 5'(PRELOAD_SLICES);

    if (RAM_DATA_WIDTH != 16) begin : g_bad_data_width
        $error("rgb_slice_writer: RAM_DATA_WIDTH must be 16");
    end
    if (PRELOAD_SLICES < 1 || PRELOAD_SLICES > SLICES_IN_RAM) begin : g_bad_preload
        $error("rgb_slice_writer: PRELOAD_SLICES must be within 1..SLICES_IN_RAM");
    end

    // Shared 9-bit path: rounding adds 4 before the shift, truncation does not; saturate at 31.
    function automatic logic [4:0] chan5(input logic [7:0] x);
        logic [8:0] sum;
`ifdef RGB_SLICE_WRITER_ROUND_EN
        sum = {1'b0, x} + 9'd4;
`else
        sum = {1'b0, x};
`endif
        sum = sum >> 3;
        chan5 = (sum > 9'd31) ? 5'd31 : sum[4:0];
    endfunction

    state_t                    state_q, state_d;
    logic                      vs_q, vs_d;
    logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]          slice_idx_q, slice_idx_d;
    logic [RAM_ADDR_WIDTH-1:0] slice_base_q, slice_base_d;
    logic [4:0]                slice_count_q, slice_count_d;
    logic                      stream_ready_q, stream_ready_d;
    logic                      ram_we_q, ram_we_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]               ram_data_q, ram_data_d;

    logic                      frame_start;
    logic                      accept;
    logic [PIX_W-1:0]          slot;

    always_comb begin
        state_d        = state_q;
        vs_d           = vsync;
        pix_cnt_d      = pix_cnt_q;
        slice_idx_d    = slice_idx_q;
        slice_base_d   = slice_base_q;
        slice_count_d  = slice_count_q;
        stream_ready_d = stream_ready_q | (slice_count_q >= PRELOAD_CNT);
        ram_we_d       = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_data_d     = ram_data_q;
        frame_start    = vsync & ~vs_q;
        accept         = 1'b0;
        slot           = pix_cnt_q;

        case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d   = FILL;
                    pix_cnt_d = '0;
                end
            end

            FILL: begin
                // A new frame before the slice is full restarts the same slice at pixel 0.
                if (frame_start) begin
                    slot = '0;
                end
                accept = rgb_valid;
                if (accept) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = slice_base_q + RAM_ADDR_WIDTH'(slot);
                    ram_data_d = {chan5(rgb[7:0]), chan5(rgb[15:8]), 1'b0, chan5(rgb[23:16])};
                    pix_cnt_d  = slot + PIX_W'(1);
                    if (slot == LAST_PIX) begin
                        state_d = DONE;
                    end
                end else begin
                    pix_cnt_d = slot;
                end
            end

            DONE: begin
                if (slice_idx_q == LAST_IDX) begin
                    slice_idx_d  = '0;
                    slice_base_d = RAM_BASE;
                end else begin
                    slice_idx_d  = slice_idx_q + IDX_W'(1);
                    slice_base_d = slice_base_q + SLICE_STEP;
                end
                if (slice_count_q != 5'd31) begin
                    slice_count_d = slice_count_q + 5'd1;
                end
                pix_cnt_d = '0;
                state_d   = frame_start ? FILL : WAIT_FRAME;
            end

            default: begin
                state_d   = WAIT_FRAME;
                pix_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_FRAME;
            vs_q           <= 1'b0;
            pix_cnt_q      <= '0;
            slice_idx_q    <= '0;
            slice_base_q   <= RAM_BASE;
            slice_count_q  <= '0;
            stream_ready_q <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= RAM_BASE;
            ram_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            vs_q           <= vs_d;
            pix_cnt_q      <= pix_cnt_d;
            slice_idx_q    <= slice_idx_d;
            slice_base_q   <= slice_base_d;
            slice_count_q  <= slice_count_d;
            stream_ready_q <= stream_ready_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign ram_we       = ram_we_q;
    assign stream_ready = stream_ready_q;
    assign slice_count  = slice_count_q;

endmodule

`default_nettype wire
